bus_fabric: RTL and testbench
=============================

Name: bus_fabric

Overview:
- Parametrised, handshaked successor to the fixed 12-module address-decode bus.
- Connects the CPU instruction (I) and data (D) ports to NUM_MODS memory-mapped modules.
- Slaves may take multiple cycles to respond; each channel holds the CPU stalled until the slave is ready, the channel times out, or the address decodes to no module.
- Faults are captured in error registers and raise an interrupt line towards the interrupt controller.

Parameters:
- NUM_MODS, 12, number of attached modules; legal range 1..256.
- IDX_LSB, 24, module index = addr[31:IDX_LSB]; effective address = addr with bits [31:IDX_LSB] zeroed.
- TIMEOUT, 255, maximum WAIT cycles before the channel faults; legal range 1..65535.
- TO_W, 16, width of the timeout counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_ireq  in  1  instruction fetch request
- cpu_iaddr  in  32  instruction address, word aligned
- bus_cpu_inst  out  32  fetched instruction, valid when cpu_iack=1
- cpu_iack  out  1  one-cycle I completion pulse
- cpu_drw  in  2  00 nop, 01 write, 10 read, 11 treated as nop
- cpu_daddr  in  32  data address
- cpu_bus_data  in  32  write data
- bus_cpu_data  out  32  read data, valid when cpu_dack=1
- cpu_dack  out  1  one-cycle D completion pulse
- cpu_stall  out  1  high while either channel is in WAIT
- mod_ie  out  NUM_MODS  one-hot instruction enable
- mod_de  out  NUM_MODS  one-hot data enable
- mod_iaddr, mod_daddr  out  32 each  effective addresses, latched
- mod_drw  out  2  latched cpu_drw
- mod_wdata  out  32  latched write data
- mod_inst, mod_data  in  32*NUM_MODS  flattened slave read data; module k uses bits [32k+31:32k]
- mod_irdy, mod_drdy  in  NUM_MODS  slave ready for the current enable
- err_addr  out  32  address of the first unacknowledged fault
- err_cause  out  2  00 none, 01 unmapped, 10 timeout; bit tracks the faulting channel via err_chan
- err_chan  out  1  0 = I, 1 = D
- err_irq  out  1  level interrupt, high while err_cause != 00
- err_clr  in  1  clears err_* and err_irq

Behaviour:
- Reset (rst sampled high): both channel FSMs go to IDLE and all outputs are 0, including enables, acks, stall, err_* and data.
- Reset takes priority over any in-flight transaction. Enables drop on the clock edge that samples rst; no ack is issued.
- Per-channel FSM states: IDLE, WAIT, RESP, ERR.
- IDLE:
  - Request is cpu_ireq, or cpu_drw in {01,10}.
  - On a request, latch the address, drw and wdata, and decode the index.
  - Index >= NUM_MODS: go to ERR.
  - Otherwise go to WAIT, assert the enable bit for that index, and clear the counter.
- WAIT:
  - Enable and latched outputs are held stable.
  - If the selected rdy bit is 1: capture the slave data into the response register, drop the enable, go to RESP.
  - Else if counter == TIMEOUT-1: drop the enable, go to ERR.
  - Else increment the counter.
- RESP: ack=1 for one cycle with rdata valid, then IDLE. A new request is accepted only from IDLE, so the minimum spacing between accepts is 3 cycles.
- ERR:
  - ack=1 and rdata=0 for one cycle, then IDLE.
  - A write to an unmapped or timed-out module has no effect on any slave.
- Latency: request at cycle 0, enable high in cycle 1, rdy=1 in cycle 1, ack in cycle 2.
- Rdata is held after ack until the next capture.
- I and D channels are fully independent and may target the same module concurrently; the slave sees separate ie/de.
- Error capture:
  - Record only when err_cause == 00.
  - If both channels fault in the same cycle, record D.
  - err_clr in the same cycle as a new fault: the clear wins, then the new fault is recorded on the next cycle if it is still in ERR. Because ERR lasts one cycle, the new fault is lost; this is documented and acceptable.
- Timeout counter saturates; it never wraps.

Decomposition:
- Package bus_fabric_pkg: state encoding (IDLE/WAIT/RESP/ERR), err_cause codes, drw codes.
- Sub-module bus_channel: one FSM plus latch, decode, timeout and response mux. Instantiated twice:
  - I channel with write path tied off.
  - D channel with write path active.
- The top-level module contains only the two bus_channel instances plus error capture.

Test Plan:
- Read module 3 with rdy tied high: cpu_daddr=0x0300_0010, drw=10, mod_data[3]=0xDEADBEEF → mod_de=0x008 in cycle 1, mod_daddr=0x10, dack and bus_cpu_data=0xDEADBEEF in cycle 2.
- Slow slave: mod_drdy[1] rises after 5 cycles → cpu_stall high for exactly 5 cycles, single dack, write data 0x1234 stable on mod_wdata throughout.
- Timeout with TIMEOUT=8 and rdy never asserted → enable high for 8 cycles, dack with data 0, err_cause=10, err_addr=request address, err_irq=1. Then err_clr → all err_* = 0.
- Unmapped fetch cpu_iaddr=0x2000_0000 with NUM_MODS=12 → no ie bit set, iack in cycle 1 with inst 0, err_cause=01, err_chan=0.
- Simultaneous unmapped I and D → err_chan=1. A second fault before err_clr leaves err_addr unchanged.
- rst asserted during WAIT → next cycle all enables 0, no ack, stall 0. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/bus_fabric_pkg.sv
// Shared types and encodings for the handshaked bus fabric.
// Channel FSM states, fault cause codes and CPU data-port command codes.
package bus_fabric_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10,
      ST_ERR  = 2'b11
   } chan_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_UNMAPPED = 2'b01,
      ERR_TIMEOUT  = 2'b10
   } err_cause_t;

   localparam logic [1:0] DRW_NOP   = 2'b00;
   localparam logic [1:0] DRW_WRITE = 2'b01;
   localparam logic [1:0] DRW_READ  = 2'b10;

   // 2'b11 is deliberately not a request
   function automatic logic drw_is_req(input logic [1:0] drw);
      return (drw == DRW_WRITE) || (drw == DRW_READ);
   endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// CPU-side and module-side signals of the bus fabric.
// The fabric uses the slave modport; the CPU/slave models use master.
interface bus_fabric_if #(
   parameter int NUM_MODS = 12
);
   logic                     cpu_ireq;
   logic [31:0]              cpu_iaddr;
   logic [31:0]              bus_cpu_inst;
   logic                     cpu_iack;
   logic [1:0]               cpu_drw;
   logic [31:0]              cpu_daddr;
   logic [31:0]              cpu_bus_data;
   logic [31:0]              bus_cpu_data;
   logic                     cpu_dack;
   logic                     cpu_stall;
   logic [NUM_MODS-1:0]      mod_ie;
   logic [NUM_MODS-1:0]      mod_de;
   logic [31:0]              mod_iaddr;
   logic [31:0]              mod_daddr;
   logic [1:0]               mod_drw;
   logic [31:0]              mod_wdata;
   logic [32*NUM_MODS-1:0]   mod_inst;
   logic [32*NUM_MODS-1:0]   mod_data;
   logic [NUM_MODS-1:0]      mod_irdy;
   logic [NUM_MODS-1:0]      mod_drdy;
   logic [31:0]              err_addr;
   logic [1:0]               err_cause;
   logic                     err_chan;
   logic                     err_irq;
   logic                     err_clr;

   modport master (
      output cpu_ireq, cpu_iaddr, cpu_drw, cpu_daddr, cpu_bus_data,
      output mod_inst, mod_data, mod_irdy, mod_drdy, err_clr,
      input  bus_cpu_inst, cpu_iack, bus_cpu_data, cpu_dack, cpu_stall,
      input  mod_ie, mod_de, mod_iaddr, mod_daddr, mod_drw, mod_wdata,
      input  err_addr, err_cause, err_chan, err_irq
   );

   modport slave (
      input  cpu_ireq, cpu_iaddr, cpu_drw, cpu_daddr, cpu_bus_data,
      input  mod_inst, mod_data, mod_irdy, mod_drdy, err_clr,
      output bus_cpu_inst, cpu_iack, bus_cpu_data, cpu_dack, cpu_stall,
      output mod_ie, mod_de, mod_iaddr, mod_daddr, mod_drw, mod_wdata,
      output err_addr, err_cause, err_chan, err_irq
   );
endinterface

// File: rtl/bus_channel.sv
// One bus channel: request latch, module decode, timeout and response capture.
// Instantiated once for instruction fetch and once for data access.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transaction; accepts a request and decodes the module index
// ST_WAIT | enable held on the selected module until rdy or timeout
// ST_RESP | one-cycle ack with captured slave data
// ST_ERR  | one-cycle ack with zero data; fault visible to error capture
module bus_channel
   import bus_fabric_pkg::*;
#(
   parameter int NUM_MODS = 12,
   parameter int IDX_LSB  = 24,
   parameter int TIMEOUT  = 255,
   parameter int TO_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic [31:0]            addr,
   input  logic [1:0]             drw,
   input  logic [31:0]            wdata,
   input  logic [32*NUM_MODS-1:0] mod_rdata,
   input  logic [NUM_MODS-1:0]    mod_rdy,
   output logic [NUM_MODS-1:0]    en,
   output logic [31:0]            eff_addr,
   output logic [1:0]             drw_q,
   output logic [31:0]            wdata_q,
   output logic [31:0]            rdata,
   output logic                   ack,
   output logic                   busy,
   output logic                   fault,
   output err_cause_t             fault_cause,
   output logic [31:0]            fault_addr
);

   localparam logic [31:0]   ADDR_MASK = 32'((64'd1 << IDX_LSB) - 64'd1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   chan_state_t         state_q, state_d;
   logic [NUM_MODS-1:0] en_q, en_d;
   logic [TO_W-1:0]     cnt_q, cnt_d;
   logic [31:0]         resp_q, resp_d;
   logic [31:0]         addr_q, addr_d;
   logic [1:0]          drw_r, drw_d;
   logic [31:0]         wdata_r, wdata_d;
   err_cause_t          cause_q, cause_d;

   logic [31:0]         idx;
   logic                mapped;
   logic [NUM_MODS-1:0] dec;
   logic [31:0]         sel_data;
   logic                sel_rdy;

   assign idx    = addr >> IDX_LSB;
   assign mapped = idx < 32'(NUM_MODS);

   always_comb begin
      dec = '0;
      for (int k = 0; k < NUM_MODS; k++) begin
         dec[k] = (idx == 32'(k));
      end
   end

   // en_q is one-hot, so an OR-reduction acts as the response mux
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_MODS; k++) begin
         if (en_q[k]) begin
            sel_data = sel_data | mod_rdata[32*k +: 32];
         end
      end
   end

   assign sel_rdy = |(en_q & mod_rdy);

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      addr_d  = addr_q;
      drw_d   = drw_r;
      wdata_d = wdata_r;
      cause_d = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = addr;
               drw_d   = drw;
               wdata_d = wdata;
               cnt_d   = '0;
               if (mapped) begin
                  en_d    = dec;
                  state_d = ST_WAIT;
               end else begin
                  resp_d  = '0;
                  cause_d = ERR_UNMAPPED;
                  state_d = ST_ERR;
               end
            end
         end
         ST_WAIT: begin
            if (sel_rdy) begin
               resp_d  = sel_data;
               en_d    = '0;
               state_d = ST_RESP;
            end else if (cnt_q == TO_LAST) begin
               resp_d  = '0;
               en_d    = '0;
               cause_d = ERR_TIMEOUT;
               state_d = ST_ERR;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         en_q    <= '0;
         cnt_q   <= '0;
         resp_q  <= '0;
         addr_q  <= '0;
         drw_r   <= DRW_NOP;
         wdata_r <= '0;
         cause_q <= ERR_NONE;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         addr_q  <= addr_d;
         drw_r   <= drw_d;
         wdata_r <= wdata_d;
         cause_q <= cause_d;
      end
   end

   assign en          = en_q;
   assign eff_addr    = addr_q & ADDR_MASK;
   assign drw_q       = drw_r;
   assign wdata_q     = wdata_r;
   assign rdata       = resp_q;
   assign ack         = (state_q == ST_RESP) || (state_q == ST_ERR);
   assign busy        = (state_q == ST_WAIT);
   assign fault       = (state_q == ST_ERR);
   assign fault_cause = cause_q;
   assign fault_addr  = addr_q;

endmodule

// File: rtl/bus_fabric.sv
// Bus fabric top: independent I and D channels plus first-fault capture
// that drives the level interrupt towards the interrupt controller.
module bus_fabric
   import bus_fabric_pkg::*;
#(
   parameter int NUM_MODS = 12,
   parameter int IDX_LSB  = 24,
   parameter int TIMEOUT  = 255,
   parameter int TO_W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   bus_fabric_if.slave  bus
);

   logic        i_busy, d_busy;
   logic        i_fault, d_fault;
   err_cause_t  i_cause, d_cause;
   logic [31:0] i_faddr, d_faddr;
   logic        d_req;

   err_cause_t  err_cause_q;
   logic [31:0] err_addr_q;
   logic        err_chan_q;

   assign d_req = drw_is_req(bus.cpu_drw);

   // Fetch channel never writes: command and write data are tied off
   bus_channel #(
      .NUM_MODS (NUM_MODS),
      .IDX_LSB  (IDX_LSB),
      .TIMEOUT  (TIMEOUT),
      .TO_W     (TO_W)
   ) u_ich (
      .clk         (clk),
      .rst         (rst),
      .req         (bus.cpu_ireq),
      .addr        (bus.cpu_iaddr),
      .drw         (DRW_READ),
      .wdata       (32'h0),
      .mod_rdata   (bus.mod_inst),
      .mod_rdy     (bus.mod_irdy),
      .en          (bus.mod_ie),
      .eff_addr    (bus.mod_iaddr),
      .drw_q       (),
      .wdata_q     (),
      .rdata       (bus.bus_cpu_inst),
      .ack         (bus.cpu_iack),
      .busy        (i_busy),
      .fault       (i_fault),
      .fault_cause (i_cause),
      .fault_addr  (i_faddr)
   );

   bus_channel #(
      .NUM_MODS (NUM_MODS),
      .IDX_LSB  (IDX_LSB),
      .TIMEOUT  (TIMEOUT),
      .TO_W     (TO_W)
   ) u_dch (
      .clk         (clk),
      .rst         (rst),
      .req         (d_req),
      .addr        (bus.cpu_daddr),
      .drw         (bus.cpu_drw),
      .wdata       (bus.cpu_bus_data),
      .mod_rdata   (bus.mod_data),
      .mod_rdy     (bus.mod_drdy),
      .en          (bus.mod_de),
      .eff_addr    (bus.mod_daddr),
      .drw_q       (bus.mod_drw),
      .wdata_q     (bus.mod_wdata),
      .rdata       (bus.bus_cpu_data),
      .ack         (bus.cpu_dack),
      .busy        (d_busy),
      .fault       (d_fault),
      .fault_cause (d_cause),
      .fault_addr  (d_faddr)
   );

   assign bus.cpu_stall = i_busy | d_busy;

   // Clear beats a coincident fault; D wins when both channels fault together
   always_ff @(posedge clk) begin
      if (rst || bus.err_clr) begin
         err_cause_q <= ERR_NONE;
         err_addr_q  <= '0;
         err_chan_q  <= 1'b0;
      end else if (err_cause_q == ERR_NONE) begin
         if (d_fault) begin
            err_cause_q <= d_cause;
            err_addr_q  <= d_faddr;
            err_chan_q  <= 1'b1;
         end else if (i_fault) begin
            err_cause_q <= i_cause;
            err_addr_q  <= i_faddr;
            err_chan_q  <= 1'b0;
         end
      end
   end

   assign bus.err_cause = err_cause_q;
   assign bus.err_addr  = err_addr_q;
   assign bus.err_chan  = err_chan_q;
   assign bus.err_irq   = (err_cause_q != ERR_NONE);

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: 12 modules, index in addr[31:24], TIMEOUT=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_fabric;
   import bus_fabric_pkg::*;

   localparam int NM = 12;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   stalls, acks, bad, de_cnt;
   logic [31:0] ack_data;

   bus_fabric_if #(.NUM_MODS(NM)) bus ();

   bus_fabric #(
      .NUM_MODS (NM),
      .IDX_LSB  (24),
      .TIMEOUT  (8),
      .TO_W     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.cpu_ireq = 1'b0;
      bus.cpu_iaddr = '0;
      bus.cpu_drw = DRW_NOP;
      bus.cpu_daddr = '0;
      bus.cpu_bus_data = '0;
      bus.mod_inst = '0;
      bus.mod_data = '0;
      bus.mod_irdy = '0;
      bus.mod_drdy = '0;
      bus.err_clr = 1'b0;
      bus.mod_data[32*1 +: 32] = 32'h1111_1111;
      bus.mod_data[32*2 +: 32] = 32'h55AA_55AA;
      bus.mod_data[32*3 +: 32] = 32'hDEAD_BEEF;
      bus.mod_data[32*4 +: 32] = 32'h4444_0004;
      bus.mod_inst[32*0 +: 32] = 32'hCAFE_0001;
      step();
      step();

      // reset state
      check("rst_de",    32'(bus.mod_de), 32'h0);
      check("rst_ie",    32'(bus.mod_ie), 32'h0);
      check("rst_dack",  32'(bus.cpu_dack), 32'h0);
      check("rst_iack",  32'(bus.cpu_iack), 32'h0);
      check("rst_stall", 32'(bus.cpu_stall), 32'h0);
      check("rst_cause", 32'(bus.err_cause), 32'h0);
      check("rst_irq",   32'(bus.err_irq), 32'h0);
      check("rst_data",  bus.bus_cpu_data, 32'h0);
      rst = 1'b0;
      step();

      // read module 3, rdy tied high
      bus.mod_drdy[3] = 1'b1;
      bus.cpu_daddr = 32'h0300_0010;
      bus.cpu_drw = DRW_READ;
      step();
      check("rd_de",    32'(bus.mod_de), 32'h008);
      check("rd_daddr", bus.mod_daddr, 32'h10);
      check("rd_drw",   32'(bus.mod_drw), 32'h2);
      check("rd_stall", 32'(bus.cpu_stall), 32'h1);
      check("rd_noack", 32'(bus.cpu_dack), 32'h0);
      bus.cpu_drw = DRW_NOP;
      step();
      check("rd_dack",  32'(bus.cpu_dack), 32'h1);
      check("rd_data",  bus.bus_cpu_data, 32'hDEAD_BEEF);
      check("rd_de_off", 32'(bus.mod_de), 32'h0);
      step();
      check("rd_ack1cyc", 32'(bus.cpu_dack), 32'h0);
      check("rd_hold",  bus.bus_cpu_data, 32'hDEAD_BEEF);
      bus.mod_drdy = '0;

      // drw=11 is a nop
      bus.cpu_drw = 2'b11;
      step();
      check("nop_de",    32'(bus.mod_de), 32'h0);
      check("nop_stall", 32'(bus.cpu_stall), 32'h0);
      bus.cpu_drw = DRW_NOP;
      step();

      // slow write to module 1, ready in the fifth wait cycle
      bus.cpu_daddr = 32'h0100_0040;
      bus.cpu_bus_data = 32'h0000_1234;
      bus.cpu_drw = DRW_WRITE;
      step();
      check("wr_de", 32'(bus.mod_de), 32'h002);
      bus.cpu_drw = DRW_NOP;
      bus.cpu_bus_data = 32'hFFFF_FFFF;
      stalls = 0; acks = 0; bad = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.cpu_stall) stalls++;
         if (bus.cpu_dack) acks++;
         if (bus.mod_de != '0 && bus.mod_wdata !== 32'h0000_1234) bad++;
         bus.mod_drdy[1] = (stalls == 5) && bus.cpu_stall;
         step();
      end
      bus.mod_drdy = '0;
      check("wr_stall_cycles", 32'(stalls), 32'd5);
      check("wr_acks",   32'(acks), 32'd1);
      check("wr_wdata_stable", 32'(bad), 32'd0);
      check("wr_drw",    32'(bus.mod_drw), 32'h1);
      check("wr_daddr",  bus.mod_daddr, 32'h40);
      check("wr_noerr",  32'(bus.err_cause), 32'h0);

      // timeout on module 2
      bus.cpu_daddr = 32'h0200_0000;
      bus.cpu_drw = DRW_READ;
      step();
      bus.cpu_drw = DRW_NOP;
      de_cnt = 0; acks = 0; ack_data = 32'hFFFF_FFFF;
      for (int c = 0; c < 14; c++) begin
         if (bus.mod_de != '0) de_cnt++;
         if (bus.cpu_dack) begin
            acks++;
            ack_data = bus.bus_cpu_data;
         end
         step();
      end
      check("to_en_cycles", 32'(de_cnt), 32'd8);
      check("to_acks",  32'(acks), 32'd1);
      check("to_data",  ack_data, 32'h0);
      check("to_cause", 32'(bus.err_cause), 32'h2);
      check("to_addr",  bus.err_addr, 32'h0200_0000);
      check("to_chan",  32'(bus.err_chan), 32'h1);
      check("to_irq",   32'(bus.err_irq), 32'h1);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("clr_cause", 32'(bus.err_cause), 32'h0);
      check("clr_addr",  bus.err_addr, 32'h0);
      check("clr_chan",  32'(bus.err_chan), 32'h0);
      check("clr_irq",   32'(bus.err_irq), 32'h0);

      // good fetch from module 0
      bus.mod_irdy[0] = 1'b1;
      bus.cpu_iaddr = 32'h0000_0100;
      bus.cpu_ireq = 1'b1;
      step();
      bus.cpu_ireq = 1'b0;
      check("if_ie",    32'(bus.mod_ie), 32'h001);
      check("if_iaddr", bus.mod_iaddr, 32'h100);
      step();
      check("if_iack",  32'(bus.cpu_iack), 32'h1);
      check("if_inst",  bus.bus_cpu_inst, 32'hCAFE_0001);
      bus.mod_irdy = '0;
      step();

      // unmapped fetch
      bus.cpu_iaddr = 32'h2000_0000;
      bus.cpu_ireq = 1'b1;
      step();
      bus.cpu_ireq = 1'b0;
      check("um_ie",   32'(bus.mod_ie), 32'h0);
      check("um_iack", 32'(bus.cpu_iack), 32'h1);
      check("um_inst", bus.bus_cpu_inst, 32'h0);
      step();
      check("um_cause", 32'(bus.err_cause), 32'h1);
      check("um_chan",  32'(bus.err_chan), 32'h0);
      check("um_addr",  bus.err_addr, 32'h2000_0000);
      check("um_irq",   32'(bus.err_irq), 32'h1);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;

      // simultaneous unmapped I and D, then a second fault before clear
      bus.cpu_iaddr = 32'h1000_0000;
      bus.cpu_ireq = 1'b1;
      bus.cpu_daddr = 32'h0C00_0004;
      bus.cpu_drw = DRW_WRITE;
      step();
      bus.cpu_ireq = 1'b0;
      bus.cpu_drw = DRW_NOP;
      check("both_iack", 32'(bus.cpu_iack), 32'h1);
      check("both_dack", 32'(bus.cpu_dack), 32'h1);
      check("both_de",   32'(bus.mod_de), 32'h0);
      step();
      check("both_chan",  32'(bus.err_chan), 32'h1);
      check("both_addr",  bus.err_addr, 32'h0C00_0004);
      check("both_cause", 32'(bus.err_cause), 32'h1);
      bus.cpu_iaddr = 32'hFF00_0000;
      bus.cpu_ireq = 1'b1;
      step();
      bus.cpu_ireq = 1'b0;
      step();
      check("second_addr", bus.err_addr, 32'h0C00_0004);
      check("second_chan", 32'(bus.err_chan), 32'h1);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;

      // reset during wait on both channels
      bus.cpu_daddr = 32'h0400_0008;
      bus.cpu_drw = DRW_READ;
      bus.cpu_iaddr = 32'h0500_0000;
      bus.cpu_ireq = 1'b1;
      step();
      bus.cpu_drw = DRW_NOP;
      bus.cpu_ireq = 1'b0;
      check("rw_de",    32'(bus.mod_de), 32'h010);
      check("rw_ie",    32'(bus.mod_ie), 32'h020);
      check("rw_stall", 32'(bus.cpu_stall), 32'h1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rw_rst_de",    32'(bus.mod_de), 32'h0);
      check("rw_rst_ie",    32'(bus.mod_ie), 32'h0);
      check("rw_rst_stall", 32'(bus.cpu_stall), 32'h0);
      check("rw_rst_dack",  32'(bus.cpu_dack), 32'h0);
      check("rw_rst_iack",  32'(bus.cpu_iack), 32'h0);
      step();
      check("rw_late_dack", 32'(bus.cpu_dack), 32'h0);
      check("rw_late_iack", 32'(bus.cpu_iack), 32'h0);

      // fresh read after reset
      bus.mod_drdy[4] = 1'b1;
      bus.cpu_drw = DRW_READ;
      step();
      bus.cpu_drw = DRW_NOP;
      check("fr_de",    32'(bus.mod_de), 32'h010);
      check("fr_daddr", bus.mod_daddr, 32'h8);
      step();
      check("fr_dack",  32'(bus.cpu_dack), 32'h1);
      check("fr_data",  bus.bus_cpu_data, 32'h4444_0004);
      bus.mod_drdy = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
